// File: rtl/dac_spi_responder_if.sv
// SPI pins plus decoded DAC state and frame status of the SPI DAC responder.
interface dac_spi_responder_if #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 12
);
    logic                      cs;
    logic                      sclk;
    logic                      mosi;
    logic [CHANNELS*WIDTH-1:0] dac_value;
    logic                      ref_enable;
    logic                      frame_valid;
    logic                      frame_error;
    logic [3:0]                frame_cmd;
    logic [3:0]                frame_addr;
    logic [WIDTH-1:0]          frame_data;

    modport master (
        output cs, sclk, mosi,
        input  dac_value, ref_enable, frame_valid, frame_error,
               frame_cmd, frame_addr, frame_data
    );

    modport slave (
        input  cs, sclk, mosi,
        output dac_value, ref_enable, frame_valid, frame_error,
               frame_cmd, frame_addr, frame_data
    );
endinterface

// File: rtl/dac_spi_responder.sv
// Receive side of an 8-channel 12-bit SPI DAC: deserialises 32-bit frames
// and decodes them into per-channel input and DAC registers.
module dac_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int CHANNELS    = 8,
    parameter int WIDTH       = 12
) (
    input  logic               clk,
    input  logic               rst,
    dac_spi_responder_if.slave bus
);

    typedef enum logic [1:0] {DISARMED, IDLE, SHIFT, COMMIT} state_t;

    localparam logic [4:0] NCH = 5'(CHANNELS);

    logic [SYNC_STAGES-1:0] cs_sy, sclk_sy, mosi_sy;
    logic                   cs_d, sclk_d;
    logic                   cs_s, sclk_s, mosi_s;
    logic                   cs_rise, cs_fall, sclk_fall;

    state_t                 state;
    // Bits [31:28] of a frame are don't-care, so only the low 28 bits are kept.
    logic [27:0]            shreg;
    logic [5:0]             count;

    logic [CHANNELS-1:0][WIDTH-1:0] in_reg, dac_reg;
    logic [CHANNELS-1:0][WIDTH-1:0] in_nxt, dac_nxt;

    logic [3:0]       c_cmd, c_addr;
    logic [WIDTH-1:0] c_data;
    logic             c_all, c_ok;

    assign cs_s   = cs_sy[SYNC_STAGES-1];
    assign sclk_s = sclk_sy[SYNC_STAGES-1];
    assign mosi_s = mosi_sy[SYNC_STAGES-1];

    assign cs_rise   =  cs_s & ~cs_d;
    assign cs_fall   = ~cs_s &  cs_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    assign c_cmd  = shreg[27:24];
    assign c_addr = shreg[23:20];
    assign c_data = shreg[8 +: WIDTH];
    assign c_all  = (c_addr == 4'hF);

    assign bus.dac_value = dac_reg;

    // Synchronise the SPI pins. Everything resets low so a reset in the middle
    // of a frame leaves the FSM disarmed until cs really goes high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sy   <= '0;
            sclk_sy <= '0;
            mosi_sy <= '0;
            cs_d    <= 1'b0;
            sclk_d  <= 1'b0;
        end else begin
            cs_sy   <= {cs_sy[SYNC_STAGES-2:0], bus.cs};
            sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], bus.sclk};
            mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], bus.mosi};
            cs_d    <= cs_s;
            sclk_d  <= sclk_s;
        end
    end

    // Decode the captured frame into next-state register values and a verdict.
    always_comb begin
        in_nxt  = in_reg;
        dac_nxt = dac_reg;
        c_ok    = 1'b0;
        if (c_cmd == 4'b1000) begin
            c_ok = 1'b1;
        end else if (c_cmd[3:2] == 2'b00 && (c_all || {1'b0, c_addr} < NCH)) begin
            c_ok = 1'b1;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (c_all || c_addr == 4'(ch)) begin
                    case (c_cmd[1:0])
                        2'b00, 2'b10: in_nxt[ch]  = c_data;
                        2'b01:        dac_nxt[ch] = in_reg[ch];
                        default: begin
                            in_nxt[ch]  = c_data;
                            dac_nxt[ch] = c_data;
                        end
                    endcase
                end
            end
            // Load-all sees the input register value written by this same frame.
            if (c_cmd[1:0] == 2'b10) dac_nxt = in_nxt;
        end
    end

    // Frame FSM: shift on sclk falls, commit on cs rise, registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= DISARMED;
            shreg           <= '0;
            count           <= '0;
            in_reg          <= '0;
            dac_reg         <= '0;
            bus.ref_enable  <= 1'b0;
            bus.frame_cmd   <= '0;
            bus.frame_addr  <= '0;
            bus.frame_data  <= '0;
            bus.frame_valid <= 1'b0;
            bus.frame_error <= 1'b0;
        end else begin
            bus.frame_valid <= 1'b0;
            bus.frame_error <= 1'b0;
            case (state)
                DISARMED: if (cs_s) state <= IDLE;
                IDLE: begin
                    if (cs_fall) begin
                        shreg <= '0;
                        count <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A cs rise in the same cycle as an sclk fall ends the frame
                    // without shifting that edge.
                    if (cs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_fall) begin
                        shreg <= {shreg[26:0], mosi_s};
                        if (count != 6'd33) count <= count + 6'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    if (count == 6'd32) begin
                        bus.frame_cmd  <= c_cmd;
                        bus.frame_addr <= c_addr;
                        bus.frame_data <= c_data;
                        if (c_ok) begin
                            in_reg  <= in_nxt;
                            dac_reg <= dac_nxt;
                            if (c_cmd == 4'b1000) bus.ref_enable <= shreg[0];
                            bus.frame_valid <= 1'b1;
                        end else begin
                            bus.frame_error <= 1'b1;
                        end
                    end else if (count != 6'd0) begin
                        bus.frame_error <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_responder.sv
// Directed-vector bench with a scoreboard for dac_spi_responder.
module tb_dac_spi_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dac_spi_responder_if #(.CHANNELS(8), .WIDTH(12)) bus ();

    dac_spi_responder #(.SYNC_STAGES(2), .CHANNELS(8), .WIDTH(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          err;
        logic [95:0] dac;
        logic        refe;
        logic [3:0]  cmd;
        logic [3:0]  addr;
        logic [11:0] data;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic expect_frame(input bit err, input logic [95:0] dac, input logic refe,
                                input logic [3:0] cmd, input logic [3:0] addr,
                                input logic [11:0] data);
        exp_t e;
        e.err = err; e.dac = dac; e.refe = refe;
        e.cmd = cmd; e.addr = addr; e.data = data;
        q.push_back(e);
    endtask

    // Monitor: one pulse per frame, then the committed state the next cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.frame_valid || bus.frame_error) begin
                if (bus.frame_valid && bus.frame_error)
                    chk("pulse_exclusive", 96'd1, 96'd0);
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {94'd0, bus.frame_error, bus.frame_valid}, 96'd0);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", {94'd0, bus.frame_error, bus.frame_valid},
                        {94'd0, e.err, !e.err});
                    @(negedge clk);
                    chk("dac_value", bus.dac_value, e.dac);
                    chk("ref_enable", {95'd0, bus.ref_enable}, {95'd0, e.refe});
                    chk("frame_fields", {76'd0, bus.frame_cmd, bus.frame_addr, bus.frame_data},
                        {76'd0, e.cmd, e.addr, e.data});
                end
            end
        end
    end

    // Shift nbits of word MSB first (zeros past bit 0); optionally pulse rst
    // after rst_at bits.
    task automatic send(input logic [31:0] word, input int nbits, input int rst_at);
        @(posedge clk);
        bus.cs = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                chk("reset_mid_frame_dac", bus.dac_value, 96'd0);
                chk("reset_mid_frame_ref", {95'd0, bus.ref_enable}, 96'd0);
                rst = 1'b0;
            end
            bus.mosi = (i < 32) ? word[31-i] : 1'b0;
            @(posedge clk);
            bus.sclk = 1'b1;
            repeat (3) @(posedge clk);
            bus.sclk = 1'b0;
            repeat (3) @(posedge clk);
        end
        repeat (2) @(posedge clk);
        bus.cs = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d expected pulses still outstanding", q.size());
            q.delete();
        end
    endtask

    initial begin
        bus.cs = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dac", bus.dac_value, 96'd0);
        chk("reset_flags", {92'd0, bus.ref_enable, bus.frame_valid, bus.frame_error, 1'b0}, 96'd0);
        chk("reset_fields", {76'd0, bus.frame_cmd, bus.frame_addr, bus.frame_data}, 96'd0);
        rst = 1'b0;
        repeat (6) @(posedge clk);

        // 1: setup, reference on
        expect_frame(0, 96'd0, 1'b1, 4'h8, 4'h0, 12'h000);
        send(32'h0800_0001, 32, -1); drain();
        // 2: write+update ch5 = 12
        expect_frame(0, 96'h00C << 60, 1'b1, 4'h3, 4'h5, 12'h00C);
        send(32'h0350_0C00, 32, -1); drain();
        // 3: write input ch2 only, then update ch2
        expect_frame(0, 96'h00C << 60, 1'b1, 4'h0, 4'h2, 12'hABC);
        send(32'h002A_BC00, 32, -1); drain();
        expect_frame(0, (96'h00C << 60) | (96'hABC << 24), 1'b1, 4'h1, 4'h2, 12'h000);
        send(32'h0120_0000, 32, -1); drain();
        // 4: broadcast write+update, then unsupported cmd
        expect_frame(0, {8{12'h7FF}}, 1'b1, 4'h3, 4'hF, 12'h7FF);
        send(32'h03F7_FF00, 32, -1); drain();
        expect_frame(1, {8{12'h7FF}}, 1'b1, 4'h7, 4'h0, 12'h123);
        send(32'h0701_2300, 32, -1); drain();
        // out-of-range address
        expect_frame(1, {8{12'h7FF}}, 1'b1, 4'h0, 4'h9, 12'h001);
        send(32'h0090_0100, 32, -1); drain();
        // write ch3 then load all: ch3 picks up the new value
        expect_frame(0, {{4{12'h7FF}}, 12'h456, {3{12'h7FF}}}, 1'b1, 4'h2, 4'h3, 12'h456);
        send(32'h0234_5600, 32, -1); drain();
        // 5: bad lengths keep regs and fields; empty frame is silent
        expect_frame(1, {{4{12'h7FF}}, 12'h456, {3{12'h7FF}}}, 1'b1, 4'h2, 4'h3, 12'h456);
        send(32'h0310_0500, 31, -1); drain();
        expect_frame(1, {{4{12'h7FF}}, 12'h456, {3{12'h7FF}}}, 1'b1, 4'h2, 4'h3, 12'h456);
        send(32'h0310_0500, 33, -1); drain();
        send(32'h0310_0500, 0, -1); drain();
        // 6: reset mid-frame aborts silently, next frame is accepted
        send(32'h0310_0500, 32, 16); drain();
        expect_frame(0, 96'h005 << 12, 1'b0, 4'h3, 4'h1, 12'h005);
        send(32'h0310_0500, 32, -1); drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
